// File: rtl/axi_adc_jesd204_pkg.sv
// Shared JESD204 ADC definitions: alignment state encoding, SOF offset width,
// and the octet-to-sample mapping used by both RX and TX cores.
package axi_adc_jesd204_pkg;

    localparam int OFF_W = 2;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } align_state_t;

    // First-received octet becomes the sample MSB; hi picks the upper octet pair.
    function automatic logic [15:0] octets_to_sample(input logic [31:0] word, input logic hi);
        return hi ? {word[23:16], word[31:24]} : {word[7:0], word[15:8]};
    endfunction

endpackage

// File: rtl/axi_adc_jesd204_rx_align_if.sv
// Link-layer input and ADC-side output bundle for the JESD204 RX aligner.
// master drives the link side, slave is the aligner.
interface axi_adc_jesd204_rx_align_if #(
    parameter int NUM_LANES     = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int ERR_CNT_WIDTH = 16
) ();
    localparam int DATA_W = NUM_CHANNELS * 2 * (NUM_LANES / NUM_CHANNELS) * 16;

    logic [NUM_LANES*32-1:0]  rx_data;
    logic                     rx_valid;
    logic [3:0]               rx_sof;
    logic                     adc_valid;
    logic [DATA_W-1:0]        adc_data;
    logic                     adc_locked;
    logic                     adc_sof_err;
    logic [ERR_CNT_WIDTH-1:0] adc_sof_err_cnt;

    modport master (
        output rx_data, rx_valid, rx_sof,
        input  adc_valid, adc_data, adc_locked, adc_sof_err, adc_sof_err_cnt
    );

    modport slave (
        input  rx_data, rx_valid, rx_sof,
        output adc_valid, adc_data, adc_locked, adc_sof_err, adc_sof_err_cnt
    );
endinterface

// File: rtl/axi_adc_jesd204_lane_align.sv
// Per-lane octet rotator: holds the previous valid word and shifts {cur, prev} by off octets.
// Latency: combinational from cur/prev; prev updates on load.
// Backpressure: none, prev simply holds while load is low.
module axi_adc_jesd204_lane_align
    import axi_adc_jesd204_pkg::*;
(
    input  logic             rx_clk,
    input  logic             rx_rstn,
    input  logic [31:0]      cur,
    input  logic             load,
    input  logic [OFF_W-1:0] off,
    output logic [31:0]      al
);
    logic [31:0] prev;

    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            prev <= '0;
        end else if (load) begin
            prev <= cur;
        end
    end

    // Frame starts at octet 'off' of prev and spills into the low octets of cur.
    always_comb begin
        al = prev;
        case (off)
            2'd1:    al = {cur[7:0],  prev[31:8]};
            2'd2:    al = {cur[15:0], prev[31:16]};
            2'd3:    al = {cur[23:0], prev[31:24]};
            default: al = prev;
        endcase
    end

endmodule

// File: rtl/axi_adc_jesd204_rx_align.sv
// JESD204 RX frame aligner + MSB-first sample unpack; SOF checking under ADC_JESD204_RX_SOF_CHECK_EN.
// Latency: 2 rx_clk from the SOF-aligned word to adc_data/adc_valid (prev stage + output register).
// Backpressure: none; rx_valid low just yields an adc_valid-low cycle with adc_data held.
module axi_adc_jesd204_rx_align
    import axi_adc_jesd204_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                             rx_clk,
    input  logic                             rx_rstn,
    axi_adc_jesd204_rx_align_if.slave        bus
);
    localparam int LPC    = NUM_LANES / NUM_CHANNELS;
    localparam int DPW    = 2 * LPC;
    localparam int DATA_W = NUM_CHANNELS * DPW * 16;

    align_state_t      state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_new;
    logic              sof_hit;
    logic              emit;
    logic [31:0]       al [NUM_LANES];
    logic [DATA_W-1:0] unpacked;
    logic [DATA_W-1:0] adc_data_q;
    logic              adc_valid_q;

    assign sof_hit = bus.rx_valid && (bus.rx_sof != 4'd0);

    // Lowest set SOF bit wins.
    always_comb begin
        off_new = 2'd0;
        if (bus.rx_sof[0])      off_new = 2'd0;
        else if (bus.rx_sof[1]) off_new = 2'd1;
        else if (bus.rx_sof[2]) off_new = 2'd2;
        else if (bus.rx_sof[3]) off_new = 2'd3;
    end

    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (sof_hit) state_d = LOCKED;
            default:  state_d = LOCKED;
        endcase
    end

    // Every valid SOF reloads the offset; it applies from the following word.
    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            off_q <= '0;
        end else if (sof_hit) begin
            off_q <= off_new;
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        axi_adc_jesd204_lane_align u_lane (
            .rx_clk  (rx_clk),
            .rx_rstn (rx_rstn),
            .cur     (bus.rx_data[32*n +: 32]),
            .load    (bus.rx_valid),
            .off     (off_q),
            .al      (al[n])
        );
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        for (genvar k = 0; k < DPW; k++) begin : g_smp
            assign unpacked[16*(c*DPW+k) +: 16] = octets_to_sample(al[c*LPC + k/2], (k % 2) == 1);
        end
    end

    // prev was loaded on the lock edge, so LOCKED alone guarantees a post-lock prev.
    assign emit = (state_q == LOCKED) && bus.rx_valid;

    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            adc_valid_q <= 1'b0;
            adc_data_q  <= '0;
        end else begin
            adc_valid_q <= emit;
            if (emit) adc_data_q <= unpacked;
        end
    end

    assign bus.adc_valid  = adc_valid_q;
    assign bus.adc_data   = adc_data_q;
    assign bus.adc_locked = (state_q == LOCKED);

`ifdef ADC_JESD204_RX_SOF_CHECK_EN
    logic                     mismatch;
    logic                     sof_err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    assign mismatch = (state_q == LOCKED) && sof_hit && (off_new != off_q);

    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            sof_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sof_err_q <= mismatch;
            if (mismatch && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.adc_sof_err     = sof_err_q;
    assign bus.adc_sof_err_cnt = err_cnt_q;
`else
    assign bus.adc_sof_err     = 1'b0;
    assign bus.adc_sof_err_cnt = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_axi_adc_jesd204_rx_align.sv
// Bench for axi_adc_jesd204_rx_align: directed table, corner sequences, and a
// randomized run checked against an octet-stream reference model.
module tb_axi_adc_jesd204_rx_align;
    localparam int NL  = 4;
    localparam int NC  = 2;
    localparam int ECW = 2;
    localparam int LPC = NL / NC;
    localparam int DPW = 2 * LPC;
    localparam int DW  = NC * DPW * 16;
`ifdef ADC_JESD204_RX_SOF_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic rx_clk  = 1'b0;
    logic rx_rstn = 1'b0;
    always #5 rx_clk = ~rx_clk;

    axi_adc_jesd204_rx_align_if #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .ERR_CNT_WIDTH(ECW)) bus ();

    axi_adc_jesd204_rx_align #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .ERR_CNT_WIDTH(ECW)) dut (
        .rx_clk  (rx_clk),
        .rx_rstn (rx_rstn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-lane stream of received octets, last two words kept.
    bit             m_locked;
    int             m_off;
    int             m_cnt;
    bit             e_valid;
    bit             e_err;
    logic [DW-1:0]  e_data;
    logic [7:0]     oct [NL][$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] s);
        int r = 0;
        for (int b = 3; b >= 0; b--) if (s[b]) r = b;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int l = 0; l < NL; l++) d[32*l +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_off    = 0;
        m_cnt    = 0;
        e_valid  = 1'b0;
        e_err    = 1'b0;
        e_data   = '0;
        for (int l = 0; l < NL; l++) begin
            oct[l].delete();
            repeat (8) oct[l].push_back(8'h00);
        end
    endtask

    task automatic check_outputs(input string name);
        chk($sformatf("%s_valid", name),  DW'(bus.adc_valid),       DW'(e_valid));
        chk($sformatf("%s_locked", name), DW'(bus.adc_locked),      DW'(m_locked));
        chk($sformatf("%s_data", name),   bus.adc_data,             e_data);
        chk($sformatf("%s_err", name),    DW'(bus.adc_sof_err),     DW'(e_err));
        chk($sformatf("%s_cnt", name),    DW'(bus.adc_sof_err_cnt), DW'(m_cnt));
    endtask

    task automatic drive(input logic [DW-1:0] data, input bit v, input logic [3:0] sof, input string name);
        bit hit;
        int nofs;
        bus.rx_data  = data;
        bus.rx_valid = v;
        bus.rx_sof   = sof;
        hit  = v && (sof != 4'd0);
        nofs = lowest(sof);
        e_valid = m_locked && v;
        if (v) begin
            for (int l = 0; l < NL; l++) begin
                for (int b = 0; b < 4; b++) oct[l].push_back(data[32*l + 8*b +: 8]);
                while (oct[l].size() > 8) void'(oct[l].pop_front());
            end
        end
        if (e_valid) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < DPW; k++) begin
                    int ln = c * LPC + k / 2;
                    int p  = m_off + 2 * (k % 2);
                    e_data[16*(c*DPW+k) +: 16] = {oct[ln][p], oct[ln][p+1]};
                end
            end
        end
        e_err = 1'b0;
        if (CHK_EN && hit && m_locked && nofs != m_off) begin
            e_err = 1'b1;
            if (m_cnt < (1 << ECW) - 1) m_cnt++;
        end
        if (hit) begin
            m_locked = 1'b1;
            m_off    = nofs;
        end
        @(posedge rx_clk);
        #1;
        check_outputs(name);
    endtask

    task automatic do_reset(input int cyc);
        rx_rstn = 1'b0;
        #1;
        for (int i = 0; i < cyc; i++) begin
            bus.rx_data  = rand_data();
            bus.rx_valid = 1'b1;
            bus.rx_sof   = 4'($urandom_range(1, 15));
            @(posedge rx_clk);
            #1;
            chk("rst_valid",  DW'(bus.adc_valid),       '0);
            chk("rst_data",   bus.adc_data,             '0);
            chk("rst_locked", DW'(bus.adc_locked),      '0);
            chk("rst_err",    DW'(bus.adc_sof_err),     '0);
            chk("rst_cnt",    DW'(bus.adc_sof_err_cnt), '0);
        end
        rx_rstn      = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 4'd0;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        logic [31:0] w;
        bit          v;
        logic [3:0]  sof;
        bit          ev;
        bit          el;
        logic [15:0] s0;
        logic [15:0] s1;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int lows;
        tbl[0] = '{1'b1, 32'h44332211, 1'b1, 4'b0001, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 32'h88776655, 1'b1, 4'b0000, 1'b1, 1'b1, 16'h1122, 16'h3344};
        tbl[2] = '{1'b0, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b1, 16'h5566, 16'h7788};
        tbl[3] = '{1'b1, 32'hBBAA0000, 1'b1, 4'b0100, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[4] = '{1'b0, 32'h0000DDCC, 1'b1, 4'b0000, 1'b1, 1'b1, 16'hAABB, 16'hCCDD};

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 4'd0;
        model_reset();
        do_reset(4);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].rst) do_reset(2);
            drive({96'h0, tbl[i].w}, tbl[i].v, tbl[i].sof, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_vec_valid", i),  DW'(bus.adc_valid),  DW'(tbl[i].ev));
            chk($sformatf("tbl%0d_vec_locked", i), DW'(bus.adc_locked), DW'(tbl[i].el));
            chk($sformatf("tbl%0d_vec_s0", i),     DW'(bus.adc_data[15:0]),  DW'(tbl[i].s0));
            chk($sformatf("tbl%0d_vec_s1", i),     DW'(bus.adc_data[31:16]), DW'(tbl[i].s1));
        end

        // rx_valid gap of three cycles mid-stream.
        do_reset(1);
        drive(rand_data(), 1'b1, 4'b0001, "gap_lock");
        drive(rand_data(), 1'b1, 4'b0000, "gap_pre");
        drive(rand_data(), 1'b1, 4'b0000, "gap_pre");
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            drive(rand_data(), 1'b0, 4'b0000, "gap_idle");
            if (!bus.adc_valid) lows++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(rand_data(), 1'b1, 4'b0000, "gap_resume");
            if (!bus.adc_valid) lows++;
        end
        chk("gap_low_count", DW'(lows), DW'(3));

        // SOF offset mismatches after locking at offset 0.
        do_reset(1);
        drive(rand_data(), 1'b1, 4'b0001, "mm_lock");
        drive(rand_data(), 1'b1, 4'b0000, "mm_word");
        drive(rand_data(), 1'b1, 4'b0010, "mm_sof1");
        chk("mm_pulse1", DW'(bus.adc_sof_err), DW'(CHK_EN));
        drive(rand_data(), 1'b1, 4'b0000, "mm_word");
        drive(rand_data(), 1'b1, 4'b0001, "mm_sof2");
        chk("mm_pulse2", DW'(bus.adc_sof_err), DW'(CHK_EN));
        drive(rand_data(), 1'b1, 4'b0000, "mm_word");
        drive({96'h0, 32'h44332211}, 1'b1, 4'b0010, "mm_sof3");
        chk("mm_pulse3", DW'(bus.adc_sof_err), DW'(CHK_EN));
        drive({96'h0, 32'h88776655}, 1'b1, 4'b0000, "mm_realign");
        chk("mm_realign_s0", DW'(bus.adc_data[15:0]),  DW'(16'h2233));
        chk("mm_realign_s1", DW'(bus.adc_data[31:16]), DW'(16'h4455));
        chk("mm_cnt3", DW'(bus.adc_sof_err_cnt), CHK_EN ? DW'(3) : DW'(0));
        drive(rand_data(), 1'b1, 4'b0100, "mm_sof4");
        chk("mm_pulse4", DW'(bus.adc_sof_err), DW'(CHK_EN));
        chk("mm_cnt_sat", DW'(bus.adc_sof_err_cnt), CHK_EN ? DW'(3) : DW'(0));
        drive(rand_data(), 1'b1, 4'b0100, "mm_same");
        chk("mm_no_pulse", DW'(bus.adc_sof_err), DW'(0));

        // Randomized traffic with gaps, SOF moves and occasional resets.
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            bit          v;
            logic [3:0]  s;
            if ($urandom_range(0, 99) == 0) do_reset(2);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            drive(rand_data(), v, s, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
